stepper_seq: RTL and testbench
==============================

# stepper_seq

Parametrised stepper-motor sequencer: next-generation replacement for the fixed free-running 4-coil stepper driver behind the tt_um top level. It adds wave, full- and half-step modes, programmable step period, a bounded or continuous move command with busy/done handshake, abort, and hold-or-release at end of move. The block sits between the ui_in/uio_in control fields and the uio_out coil pins.

## Interface
- CNT_W, 24, width of the step-period counter and `period` input
- STEPS_W, 16, width of the step-count input and internal remaining-step counter
- RAMP_START, 16, extra cycles added to the first step interval (used only with ramp compiled in)
- RAMP_DEC, 2, cycles removed from the interval on each successive step (ramp only)

- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  move request; accepted only in IDLE
- stop  in  1  abort; effective in RUN and SETTLE
- dir  in  1  1 = forward (index increments), 0 = reverse; sampled on accepted start
- mode  in  2  00 wave, 01 full (two-coil), 10 half, 11 treated as full; sampled on start
- steps  in  STEPS_W  steps to perform; 0 = continuous until stop
- period  in  CNT_W  clocks per step (P); 0 treated as 1; sampled on start
- hold  in  1  1 = keep last pattern energized after move, 0 = coils 0000; sampled on start
- coils  out  4  coil drive {A,B,C,D}
- step_pulse  out  1  one-cycle strobe coincident with each coil advance
- busy  out  1  high in RUN/SETTLE
- done  out  1  one-cycle strobe at move end (completion or abort)
- pos  out  3  current phase index

## Operation
- Phase table, index 0..7: 1000,1100,0100,0110,0010,0011,0001,1001. coils = table[pos] while energized.
- Half mode: index ±1 per step. Wave: ±2, index forced even on start (bit0 cleared). Full: ±2, index forced odd (bit0 set). Index wraps modulo 8 both directions.
- FSM: IDLE -> RUN on start (and not stop). RUN -> SETTLE after final step (steps≠0). SETTLE -> IDLE after one further interval of P. RUN/SETTLE -> IDLE on stop.
- In IDLE: coils = table[pos] if last move's hold=1, else 0000; after reset 0000.
- Remaining-step counter loaded with steps on start, decremented per step; not decremented when steps=0.
- Reset values: coils 0000, pos 0, busy 0, done 0, step_pulse 0, state IDLE, hold latch 0.
- Reset mid-move: next edge returns all to reset values; no done pulse.

## Timing
- Start sampled on edge E0: after E0 busy=1, pos aligned, coils = table[pos].
- Step n (1-based) advances pos/coils and raises step_pulse after edge E0+n·P.
- Final step N at E0+N·P; done=1, busy=0, coils per hold after E0+(N+1)·P.
- stop sampled high on edge Es in RUN/SETTLE: after Es state IDLE, done=1 for one cycle, no step on that edge even if due (stop wins), coils per hold.
- start while busy: ignored. start and stop same edge in IDLE: both ignored.
- Inputs other than stop are don't-care while busy.

## Configuration
- STEPPER_SEQ_RAMP_EN defined: interval of step 1 = P+RAMP_START; each subsequent interval reduced by RAMP_DEC, floor P; computed in CNT_W+1 bits, saturating at 2^CNT_W−1. SETTLE interval is always P.
- Not defined: every interval equals P; RAMP_START/RAMP_DEC unused; no ramp logic synthesized.

## Test plan
- Reset: rst_n low 2 cycles mid-move -> coils 0000, pos 0, busy 0, done 0, step_pulse 0; no done pulse.
- Half forward, pos 0, P=4, steps=3, hold=1: coils 1000 after E0, 1100 @E0+4, 0100 @E0+8, 0110 @E0+12, done @E0+16, coils stay 0110.
- Full reverse, pos 0, P=2, steps=2, hold=0: aligned 1100 (pos1), 1001 @E0+2, 0011 @E0+4, done @E0+6 with coils 0000.
- Wave continuous, steps=0, P=3: stop after 5th step_pulse -> exactly 5 pulses, pos wraps 0,2,4,6,0,2; one-cycle done, busy low next edge.
- Period 0 behaves as P=1 (one step per cycle); start pulsed while busy and start+stop in IDLE -> no effect on count or pos.
- With STEPPER_SEQ_RAMP_EN, RAMP_START=6, RAMP_DEC=2, P=4, steps=5 -> step intervals 10,8,6,4,4 cycles.

Source files
------------

// File: rtl/stepper_seq.sv
// stepper_seq: four-coil stepper sequencer with wave, full and half-step modes.
// It supports a programmable step period, bounded or continuous moves with a
// busy/done handshake, abort, and hold-or-release of the coils at end of move.
// Optional feature: define STEPPER_SEQ_RAMP_EN to add a start-up speed ramp.
// The first step interval is lengthened by RAMP_START and then shortened by
// RAMP_DEC per step, never dropping below the programmed period.
module stepper_seq #(
  parameter int CNT_W      = 24,
  parameter int STEPS_W    = 16,
  parameter int RAMP_START = 16,
  parameter int RAMP_DEC   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [STEPS_W-1:0] steps,
  input  logic [CNT_W-1:0]   period,
  input  logic               hold,
  output logic [3:0]         coils,
  output logic               step_pulse,
  output logic               busy,
  output logic               done,
  output logic [2:0]         pos
);

  // The ramp constants must fit in the period counter.
  if (RAMP_START < 0 || RAMP_DEC < 0 || RAMP_START >= 2**CNT_W || RAMP_DEC >= 2**CNT_W) begin : g_bad_ramp_params
    $error("stepper_seq: RAMP_START/RAMP_DEC out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         pos_q, pos_d;
  logic               hold_q, hold_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic               cont_q, cont_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   period_eff;
  logic [CNT_W-1:0]   first_ivl;
  logic [CNT_W-1:0]   next_ivl;
  logic               accept;
  logic               step_now;
  logic [2:0]         step_amt;

  // A zero period would never expire, so it runs as one clock per step.
  assign period_eff = (period == '0) ? CNT_W'(1) : period;

  // A move is accepted only from idle; a simultaneous stop cancels the start.
  assign accept   = (state_q == ST_IDLE) && start && !stop;
  // A step is due when the interval counter expires, unless stop wins that edge.
  assign step_now = (state_q == ST_RUN) && !stop && (cnt_q == CNT_W'(1));
  assign step_amt = half_q ? 3'd1 : 3'd2;

`ifdef STEPPER_SEQ_RAMP_EN
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic [CNT_W:0]   first_sum;
  logic [CNT_W:0]   dec_diff;

  // Ramp intervals: saturating first interval, then decrement down to the period.
  always_comb begin
    first_sum = {1'b0, period_eff} + (CNT_W+1)'(RAMP_START);
    first_ivl = first_sum[CNT_W] ? {CNT_W{1'b1}} : first_sum[CNT_W-1:0];
    dec_diff  = {1'b0, ivl_q} - (CNT_W+1)'(RAMP_DEC);
    if (dec_diff[CNT_W] || (dec_diff[CNT_W-1:0] < per_q)) begin
      next_ivl = per_q;
    end else begin
      next_ivl = dec_diff[CNT_W-1:0];
    end
  end

  // Track the current step interval across the ramp.
  always_comb begin
    ivl_d = ivl_q;
    if (accept) begin
      ivl_d = first_ivl;
    end else if (step_now) begin
      ivl_d = next_ivl;
    end
  end

  // Ramp interval register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ivl_q <= '0;
    end else begin
      ivl_q <= ivl_d;
    end
  end
`else
  assign first_ivl = period_eff;
  assign next_ivl  = per_q;
`endif

  // Next-state logic: move acceptance, stepping, settling and abort.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hold_d  = hold_q;
    dir_d   = dir_q;
    half_d  = half_q;
    cont_d  = cont_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          dir_d   = dir;
          hold_d  = hold;
          per_d   = period_eff;
          cnt_d   = first_ivl;
          rem_d   = steps;
          cont_d  = (steps == '0);
          case (mode)
            2'b10: begin
              half_d = 1'b1;
            end
            2'b00: begin
              half_d = 1'b0;
              pos_d  = {pos_q[2:1], 1'b0};
            end
            default: begin
              half_d = 1'b0;
              pos_d  = {pos_q[2:1], 1'b1};
            end
          endcase
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (step_now) begin
          pos_d   = dir_q ? (pos_q + step_amt) : (pos_q - step_amt);
          pulse_d = 1'b1;
          cnt_d   = next_ivl;
          if (!cont_q) begin
            rem_d = rem_q - STEPS_W'(1);
            if (rem_q == STEPS_W'(1)) begin
              state_d = ST_SETTLE;
              cnt_d   = per_q;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (stop || (cnt_q == CNT_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= 3'd0;
      hold_q  <= 1'b0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      cont_q  <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      cont_q  <= cont_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  // Coils follow the phase table while moving, or while holding after a move.
  always_comb begin
    coils = 4'b0000;
    if ((state_q != ST_IDLE) || hold_q) begin
      case (pos_q)
        3'd0:    coils = 4'b1000;
        3'd1:    coils = 4'b1100;
        3'd2:    coils = 4'b0100;
        3'd3:    coils = 4'b0110;
        3'd4:    coils = 4'b0010;
        3'd5:    coils = 4'b0011;
        3'd6:    coils = 4'b0001;
        default: coils = 4'b1001;
      endcase
    end
  end

  assign step_pulse = pulse_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign pos        = pos_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Testbench for stepper_seq: cycle-level behavioural model plus directed and
// randomized moves. The model schedules steps by absolute cycle number.
`timescale 1ns/1ps
module tb_stepper_seq;
  localparam int CNT_W      = 24;
  localparam int STEPS_W    = 16;
  localparam int RAMP_START = 6;
  localparam int RAMP_DEC   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               dir = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [STEPS_W-1:0] steps = '0;
  logic [CNT_W-1:0]   period = '0;
  logic               hold = 1'b0;
  logic [3:0]         coils;
  logic               step_pulse;
  logic               busy;
  logic               done;
  logic [2:0]         pos;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  stepper_seq #(
    .CNT_W(CNT_W),
    .STEPS_W(STEPS_W),
    .RAMP_START(RAMP_START),
    .RAMP_DEC(RAMP_DEC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .dir(dir),
    .mode(mode),
    .steps(steps),
    .period(period),
    .hold(hold),
    .coils(coils),
    .step_pulse(step_pulse),
    .busy(busy),
    .done(done),
    .pos(pos)
  );

  always #5 clk = ~clk;

  // Phase table of the motor, indexed by phase position.
  logic [3:0] phase_tab [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};

  // Behavioural model: 0 idle, 1 moving, 2 settling; steps fire at absolute cycles.
  int     m_state = 0;
  int     m_pos = 0;
  int     m_hold = 0;
  int     m_dir = 0;
  int     m_step = 1;
  int     m_left = 0;
  int     m_p = 1;
  longint m_ivl = 1;
  longint m_due = 0;
  longint cycle = 0;
  int     m_pulse = 0;
  int     m_done = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model at each rising edge using the inputs sampled there.
  always @(posedge clk) begin
    cycle++;
    m_pulse = 0;
    m_done  = 0;
    if (!rst_n) begin
      m_state = 0;
      m_pos   = 0;
      m_hold  = 0;
    end else if (m_state == 0) begin
      if (start && !stop) begin
        m_state = 1;
        m_dir   = int'(dir);
        m_hold  = int'(hold);
        m_p     = (period == '0) ? 1 : int'(period);
        m_step  = (mode == 2'b10) ? 1 : 2;
        if (mode == 2'b00) m_pos = (m_pos / 2) * 2;
        else if (mode != 2'b10) m_pos = (m_pos / 2) * 2 + 1;
        m_left  = (steps == '0) ? -1 : int'(steps);
        m_ivl   = m_p;
`ifdef STEPPER_SEQ_RAMP_EN
        m_ivl   = longint'(m_p) + RAMP_START;
        if (m_ivl > (longint'(1) << CNT_W) - 1) m_ivl = (longint'(1) << CNT_W) - 1;
`endif
        m_due   = cycle + m_ivl;
      end
    end else if (stop) begin
      m_state = 0;
      m_done  = 1;
    end else if (cycle == m_due) begin
      if (m_state == 2) begin
        m_state = 0;
        m_done  = 1;
      end else begin
        m_pos   = m_dir ? (m_pos + m_step) % 8 : (m_pos + 8 - m_step) % 8;
        m_pulse = 1;
        if (m_left > 0) m_left--;
        if (m_left == 0) begin
          m_state = 2;
          m_due   = cycle + m_p;
        end else begin
`ifdef STEPPER_SEQ_RAMP_EN
          m_ivl = (m_ivl - RAMP_DEC > m_p) ? m_ivl - RAMP_DEC : longint'(m_p);
`endif
          m_due = cycle + m_ivl;
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_coils", coils, ((m_state != 0) || (m_hold != 0)) ? phase_tab[m_pos] : 4'b0000);
      checkOutput("cmp_pos", pos, m_pos);
      checkOutput("cmp_busy", busy, (m_state != 0) ? 1 : 0);
      checkOutput("cmp_done", done, m_done);
      checkOutput("cmp_step_pulse", step_pulse, m_pulse);
    end
  end

  // Present a move request for one edge; returns at the falling edge after E0.
  task automatic applyStimulus(input logic d, input logic [1:0] m, input logic [STEPS_W-1:0] s,
                               input logic [CNT_W-1:0] p, input logic h);
    @(negedge clk);
    rst_n = 1'b1; stop = 1'b0;
    dir = d; mode = m; steps = s; period = p; hold = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int npulse);
    int c = 0;
    npulse = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
      if (step_pulse) npulse++;
    end
    checkOutput("idle_within_bound", busy, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    int t;
    int last;
    int k;
    int exp_pos [5] = '{2, 4, 6, 0, 2};
    int exp_ivl [5];
`ifdef STEPPER_SEQ_RAMP_EN
    exp_ivl = '{10, 8, 6, 4, 4};
`else
    exp_ivl = '{4, 4, 4, 4, 4};
`endif

    // Power-on reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    checkOutput("reset_coils", coils, 4'b0000);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pos", pos, 0);
    rst_n = 1'b1;

    // Half-step forward, P=4, 3 steps, hold.
    applyStimulus(1'b1, 2'b10, 16'd3, 24'd4, 1'b1);
    checkOutput("half_e0_coils", coils, 4'b1000);
    checkOutput("half_e0_busy", busy, 1);
    repeat (4) @(negedge clk);
    checkOutput("half_s1_coils", coils, 4'b1100);
    checkOutput("half_s1_pulse", step_pulse, 1);
    repeat (4) @(negedge clk);
    checkOutput("half_s2_coils", coils, 4'b0100);
    repeat (4) @(negedge clk);
    checkOutput("half_s3_coils", coils, 4'b0110);
    repeat (4) @(negedge clk);
    checkOutput("half_done", done, 1);
    checkOutput("half_done_busy", busy, 0);
    checkOutput("half_hold_coils", coils, 4'b0110);

    // Reset held low two cycles in the middle of a move.
    applyStimulus(1'b1, 2'b01, 16'd5, 24'd3, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midrst_coils", coils, 4'b0000);
      checkOutput("midrst_pos", pos, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_pulse", step_pulse, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_no_done", done, 0);

    // Full-step reverse from pos 0, P=2, 2 steps, release.
    applyStimulus(1'b0, 2'b01, 16'd2, 24'd2, 1'b0);
    checkOutput("full_e0_coils", coils, 4'b1100);
    checkOutput("full_e0_pos", pos, 1);
    repeat (2) @(negedge clk);
    checkOutput("full_s1_coils", coils, 4'b1001);
    repeat (2) @(negedge clk);
    checkOutput("full_s2_coils", coils, 4'b0011);
    repeat (2) @(negedge clk);
    checkOutput("full_done", done, 1);
    checkOutput("full_release_coils", coils, 4'b0000);

    // Wave continuous from pos 0, stopped after the fifth step.
    pulseReset();
    applyStimulus(1'b1, 2'b00, 16'd0, 24'd3, 1'b0);
    pulses = 0;
    for (int c = 0; c < 40 && pulses < 5; c++) begin
      @(negedge clk);
      if (step_pulse) begin
        checkOutput("wave_pos", pos, exp_pos[pulses]);
        pulses++;
      end
    end
    checkOutput("wave_pulse_count", pulses, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("wave_stop_done", done, 1);
    checkOutput("wave_stop_busy", busy, 0);
    checkOutput("wave_stop_no_pulse", step_pulse, 0);
    @(negedge clk);
    checkOutput("wave_done_one_cycle", done, 0);

    // Period 0 runs one step per clock; start while busy is ignored.
    applyStimulus(1'b1, 2'b10, 16'd4, 24'd0, 1'b1);
    @(negedge clk);
    n = int'(step_pulse);
    start = 1'b1;
    @(negedge clk);
    n += int'(step_pulse);
    start = 1'b0;
    waitIdle(20, pulses);
    checkOutput("p0_pulses", n + pulses, 4);
    checkOutput("p0_pos", pos, 6);
    checkOutput("p0_done", done, 1);
    // Start together with stop in idle does nothing.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checkOutput("startstop_busy", busy, 0);
    checkOutput("startstop_pos", pos, 6);
    checkOutput("startstop_coils", coils, 4'b0001);

    // Step interval sequence (ramped when the ramp is compiled in).
    applyStimulus(1'b1, 2'b10, 16'd5, 24'd4, 1'b0);
    t = 0; last = 0; k = 0;
    while (busy && k < 5 && t < 100) begin
      @(negedge clk);
      t++;
      if (step_pulse) begin
        checkOutput("interval", t - last, exp_ivl[k]);
        last = t;
        k++;
      end
    end
    checkOutput("interval_count", k, 5);
    waitIdle(40, n);

    // Randomized moves with don't-care noise, aborts and occasional resets.
    for (int it = 0; it < 40; it++) begin
      int s;
      int abort_at;
      int rst_at;
      int c;
      s = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      abort_at = (s == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : -1;
      rst_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : -1;
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), STEPS_W'(s),
                    CNT_W'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      c = 0;
      while (busy && c < 300) begin
        c++;
        start  = busy && ($urandom_range(0, 3) == 0);
        dir    = 1'($urandom_range(0, 1));
        mode   = 2'($urandom_range(0, 3));
        steps  = STEPS_W'($urandom_range(0, 7));
        period = CNT_W'($urandom_range(0, 7));
        hold   = 1'($urandom_range(0, 1));
        stop   = (c == abort_at);
        rst_n  = !(c == rst_at || c == rst_at + 1);
        @(negedge clk);
      end
      start = 1'b0; stop = 1'b0; rst_n = 1'b1;
      checkOutput("rand_idle_bound", busy, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
